mult_shift_add_ctrl: RTL and testbench

Control unit for the shift-add N×N multiplier datapath.
- Sequences the operand registers (A, B), the product register (P) and the add/shift operations, one multiplier bit per cycle.
- Talks to the system through a start/busy/done handshake.
- Sits beside the operand/product registers and the adder in the multiplier top level.
- Purely a controller: no data operands pass through it, only B's LSB and a zero flag.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_shift_add_ctrl_if.sv | 37 +++
 rtl/mult_bit_counter.sv | 32 +++
 rtl/mult_shift_add_ctrl.sv | 121 ++++++++++++
 tb/tb_mult_shift_add_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and configuration helpers for the shift-add multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 4;

  // True when a cnt_w-bit counter can reach the last iteration index.
  function automatic bit cnt_w_fits(input int width, input int cnt_w);
    return (2 ** cnt_w) > (width - 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_ctrl_if.sv
// Handshake and datapath-control bundle between the multiplier system side and its controller.
// align_shift exists only when MULT_EARLY_TERM_EN is defined.
interface mult_shift_add_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             b_lsb;
  logic             b_rest_zero;
  logic             ld_a;
  logic             ld_b;
  logic             clr_p;
  logic             add_en;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_idx;
`ifdef MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] align_shift;
`endif

  modport master (
    output start, b_lsb, b_rest_zero,
`ifdef MULT_EARLY_TERM_EN
    input  align_shift,
`endif
    input  ld_a, ld_b, clr_p, add_en, shift_en, busy, done, bit_idx
  );

  modport slave (
    input  start, b_lsb, b_rest_zero,
`ifdef MULT_EARLY_TERM_EN
    output align_shift,
`endif
    output ld_a, ld_b, clr_p, add_en, shift_en, busy, done, bit_idx
  );

endinterface

// File: rtl/mult_bit_counter.sv
// Iteration counter: synchronous clear has priority over enable; tc flags index WIDTH-1.
module mult_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_r;

  // Iteration index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_shift_add_ctrl.sv
// Shift-add multiplier controller: IDLE -> LOAD -> CALC (one bit per cycle) -> DONE.
// Define MULT_EARLY_TERM_EN to stop once the remaining multiplier bits are zero.
module mult_shift_add_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  mult_shift_add_ctrl_if.slave bus
);

  if (!cnt_w_fits(WIDTH, CNT_W)) begin : g_bad_cfg
    $error("CNT_W too small for WIDTH");
  end

  state_t           state_r;
  logic             load_r;
  logic             shift_r;
  logic             busy_r;
  logic             done_r;
  logic             tc_s;
  logic             early_s;
  logic             last_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] bit_idx_s;

`ifdef MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] align_r;
  assign early_s         = bus.b_rest_zero;
  assign bus.align_shift = align_r;
`else
  assign early_s = 1'b0;
`endif

  assign last_s    = tc_s | early_s;
  assign cnt_clr_s = (state_r == LOAD) | ((state_r == CALC) & last_s);
  assign cnt_en_s  = (state_r == CALC);

  mult_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (bit_idx_s),
    .tc  (tc_s)
  );

  // State register; outputs are registered from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      load_r  <= 1'b0;
      shift_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
      align_r <= {CNT_W{1'b0}};
`endif
    end else begin
      load_r  <= 1'b0;
      shift_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
      align_r <= {CNT_W{1'b0}};
`endif
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r <= LOAD;
            load_r  <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          state_r <= CALC;
          shift_r <= 1'b1;
          busy_r  <= 1'b1;
        end
        CALC: begin
          busy_r <= 1'b1;
          if (last_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
`ifdef MULT_EARLY_TERM_EN
            align_r <= CNT_W'(WIDTH - 1) - bit_idx_s;
`endif
          end else begin
            state_r <= CALC;
            shift_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ld_a     = load_r;
  assign bus.ld_b     = load_r;
  assign bus.clr_p    = load_r;
  assign bus.shift_en = shift_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bit_idx  = bit_idx_s;
  // Mealy add: the ternary keeps an unknown b_lsb from leaking outside CALC.
  assign bus.add_en   = (state_r == CALC) ? bus.b_lsb : 1'b0;

endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// Directed self-checking bench for mult_shift_add_ctrl with a small shift-add datapath model.
module tb_mult_shift_add_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] a_m;
  logic [3:0] b_m;
  logic [7:0] p_m;
  logic [4:0] sum_s;
  int         checks;
  int         errors;

  mult_shift_add_ctrl_if #(.CNT_W(4)) bus ();

  mult_shift_add_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.b_lsb       = b_m[0];
  assign bus.b_rest_zero = (b_m[3:1] == 3'd0);
  assign sum_s = {1'b0, p_m[7:4]} + (bus.add_en ? {1'b0, a_m} : 5'd0);

  // Operand and product registers driven by the controller outputs.
  always @(posedge clk) begin
    if (bus.ld_a) a_m <= a_in;
    if (bus.ld_b) b_m <= b_in;
    else if (bus.shift_en) b_m <= b_m >> 1;
    if (bus.clr_p) p_m <= 8'd0;
    else if (bus.shift_en) p_m <= {sum_s, p_m[3:1]};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ld"}, 16'({bus.ld_a, bus.ld_b, bus.clr_p}), 16'd0);
    chk({tag, "_as"}, 16'({bus.add_en, bus.shift_en}), 16'd0);
    chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
    chk({tag, "_done"}, 16'(bus.done), 16'd0);
  endtask

  // One operation; start sampled at edge 0, samples taken 1 time unit after each edge.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_add, input logic [7:0] exp_p,
                        input bit pulse);
    a_in  = a;
    b_in  = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("load_ld", 16'({bus.ld_a, bus.ld_b, bus.clr_p}), 16'h7);
    chk("load_as", 16'({bus.add_en, bus.shift_en}), 16'd0);
    chk("load_busy", 16'(bus.busy), 16'd1);
    chk("load_done", 16'(bus.done), 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("calc_add", 16'(bus.add_en), 16'(exp_add[i]));
      chk("calc_shift", 16'(bus.shift_en), 16'd1);
      chk("calc_ld", 16'({bus.ld_a, bus.ld_b, bus.clr_p}), 16'd0);
      chk("calc_bd", 16'({bus.busy, bus.done}), 16'h2);
      chk("calc_idx", 16'(bus.bit_idx), 16'(i));
      if (pulse && i == 1) bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_bd", 16'({bus.busy, bus.done}), 16'h3);
    chk("done_as", 16'({bus.add_en, bus.shift_en, bus.ld_a}), 16'd0);
    if (pulse) bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk_idle("post");
    chk("product", 16'(p_m), 16'(exp_p));
    if (pulse) begin
      @(posedge clk); #1;
      chk_idle("no_reload");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    a_in = 4'd0;
    b_in = 4'd0;
    a_m = 4'd0;
    b_m = 4'd0;
    p_m = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_idx", 16'(bus.bit_idx), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'd5, 4'd3, 4'b0011, 8'd15, 1'b0);
    run_op(4'd15, 4'd15, 4'b1111, 8'd225, 1'b0);
    run_op(4'd9, 4'd0, 4'b0000, 8'd0, 1'b0);
    run_op(4'd7, 4'd1, 4'b0001, 8'd7, 1'b0);
    run_op(4'd6, 4'd10, 4'b1010, 8'd60, 1'b1);

    // Start held high: LOAD at cycles 1, 8, 15, 22.
    a_in = 4'd3;
    b_in = 4'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      chk("held_ld", 16'(bus.ld_a), 16'((c % 7) == 1));
    end
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk_idle("held_end");

    // Asynchronous reset in the middle of CALC.
    a_in = 4'd5;
    b_in = 4'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_idx", 16'(bus.bit_idx), 16'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_idx", 16'(bus.bit_idx), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst_no_pending");

    run_op(4'd5, 4'd3, 4'b0011, 8'd15, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
